// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pic_pkg
//  Purpose  : Shared types and constants for the 8259-style command sequencer:
//             sequencer state encodings, CPU read-source codes and OCW2
//             command codes.
//  Revision : 1.0  initial release
// ============================================================================
package pic_pkg;

    typedef enum logic [2:0] {
        ST_UNINIT    = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } pic_state_t;

    // Read-source select presented to the bus interface
    localparam logic [1:0] C_RD_IRR  = 2'b00;
    localparam logic [1:0] C_RD_ISR  = 2'b01;
    localparam logic [1:0] C_RD_IMR  = 2'b10;
    localparam logic [1:0] C_RD_POLL = 2'b11;

    // OCW2 {R, SL, EOI} command codes
    localparam logic [2:0] C_OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] C_OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] C_OCW2_NOP          = 3'b010;
    localparam logic [2:0] C_OCW2_SP_EOI       = 3'b011;
    localparam logic [2:0] C_OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] C_OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] C_OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] C_OCW2_ROT_SP_EOI   = 3'b111;

endpackage : pic_pkg
`default_nettype wire

// File: rtl/pic_cmd_decode.sv
`default_nettype none
// ============================================================================
//  Module   : pic_cmd_decode
//  Purpose  : Combinational classification of a CPU write {A0, data}.
//  Ports    : i_a0, i_din         -> write address bit and data byte
//             o_is_icw1           -> A0=0, D4=1
//             o_is_ocw2           -> A0=0, D4:D3=00
//             o_is_ocw3           -> A0=0, D4:D3=01
//             o_is_data           -> A0=1 (ICW2/3/4 or OCW1)
//  Revision : 1.0  initial release
// ============================================================================
module pic_cmd_decode (
    input  logic       i_a0,
    input  logic [7:0] i_din,
    output logic       o_is_icw1,
    output logic       o_is_ocw2,
    output logic       o_is_ocw3,
    output logic       o_is_data
);

    assign o_is_icw1 = ~i_a0 & i_din[4];
    assign o_is_ocw2 = ~i_a0 & (i_din[4:3] == 2'b00);
    assign o_is_ocw3 = ~i_a0 & (i_din[4:3] == 2'b01);
    assign o_is_data = i_a0;

endmodule : pic_cmd_decode
`default_nettype wire

// File: rtl/pic_command_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pic_command_sequencer
//  Purpose  : Steps through the ICW1..ICW4 initialization sequence, then
//             decodes OCW1/OCW2/OCW3. Holds all configuration registers,
//             strobes OCW2 commands and selects the CPU read source.
//  Ports    : clk, rst                  -> clock, synchronous active-high reset
//             i_wr_stb, i_rd_stb        -> qualified write / end-of-read pulses
//             i_a0, i_din               -> address bit and write data
//             o_init_done               -> ICW sequence complete
//             o_ltim/o_sngl/o_ic4       -> ICW1 fields
//             o_vec_base, o_icw3        -> ICW2 / ICW3 contents
//             o_aeoi/o_ms/o_buf_mode/o_sfnm/o_upm -> ICW4 fields
//             o_imr, o_smm              -> interrupt mask, special mask mode
//             o_ocw2_valid/_cmd/_lvl    -> one-cycle OCW2 command
//             o_rd_src, o_poll_ack      -> read source, poll read completion
//  Revision : 1.0  initial release
// ============================================================================
module pic_command_sequencer
    import pic_pkg::*;
#(
    parameter logic [4:0] VEC_RESET = 5'b00000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr_stb,
    input  logic       i_rd_stb,
    input  logic       i_a0,
    input  logic [7:0] i_din,
    output logic       o_init_done,
    output logic       o_ltim,
    output logic       o_sngl,
    output logic       o_ic4,
    output logic [4:0] o_vec_base,
    output logic [7:0] o_icw3,
    output logic       o_aeoi,
    output logic       o_ms,
    output logic       o_buf_mode,
    output logic       o_sfnm,
    output logic       o_upm,
    output logic [7:0] o_imr,
    output logic       o_ocw2_valid,
    output logic [2:0] o_ocw2_cmd,
    output logic [2:0] o_ocw2_lvl,
    output logic       o_smm,
    output logic [1:0] o_rd_src,
    output logic       o_poll_ack
);

    logic w_is_icw1;
    logic w_is_ocw2;
    logic w_is_ocw3;
    logic w_is_data;

    pic_state_t r_state;
    logic       r_rd_isr;   // 0: IRR, 1: ISR
    logic       r_poll;

    pic_cmd_decode u_decode (
        .i_a0      (i_a0),
        .i_din     (i_din),
        .o_is_icw1 (w_is_icw1),
        .o_is_ocw2 (w_is_ocw2),
        .o_is_ocw3 (w_is_ocw3),
        .o_is_data (w_is_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_UNINIT;
            o_init_done  <= 1'b0;
            o_ltim       <= 1'b0;
            o_sngl       <= 1'b0;
            o_ic4        <= 1'b0;
            o_vec_base   <= VEC_RESET;
            o_icw3       <= 8'h00;
            o_aeoi       <= 1'b0;
            o_ms         <= 1'b0;
            o_buf_mode   <= 1'b0;
            o_sfnm       <= 1'b0;
            o_upm        <= 1'b0;
            o_imr        <= 8'h00;
            o_smm        <= 1'b0;
            r_rd_isr     <= 1'b0;
            r_poll       <= 1'b0;
            o_ocw2_valid <= 1'b0;
            o_ocw2_cmd   <= 3'b000;
            o_ocw2_lvl   <= 3'b000;
            o_poll_ack   <= 1'b0;
        end else begin
            o_ocw2_valid <= 1'b0;
            o_poll_ack   <= 1'b0;
            if (i_wr_stb) begin
                // ICW1 restarts the sequence from any state
                if (w_is_icw1) begin
                    o_ltim      <= i_din[3];
                    o_sngl      <= i_din[1];
                    o_ic4       <= i_din[0];
                    o_imr       <= 8'h00;
                    o_smm       <= 1'b0;
                    r_rd_isr    <= 1'b0;
                    o_init_done <= 1'b0;
                    r_state     <= ST_WAIT_ICW2;
                    if (!i_din[0]) begin
                        o_aeoi     <= 1'b0;
                        o_ms       <= 1'b0;
                        o_buf_mode <= 1'b0;
                        o_sfnm     <= 1'b0;
                        o_upm      <= 1'b0;
                    end
                end else begin
                    case (r_state)
                        ST_WAIT_ICW2: begin
                            if (w_is_data) begin
                                o_vec_base <= i_din[7:3];
                                if (!o_sngl) begin
                                    r_state <= ST_WAIT_ICW3;
                                end else if (o_ic4) begin
                                    r_state <= ST_WAIT_ICW4;
                                end else begin
                                    r_state     <= ST_READY;
                                    o_init_done <= 1'b1;
                                end
                            end
                        end
                        ST_WAIT_ICW3: begin
                            if (w_is_data) begin
                                o_icw3 <= i_din;
                                if (o_ic4) begin
                                    r_state <= ST_WAIT_ICW4;
                                end else begin
                                    r_state     <= ST_READY;
                                    o_init_done <= 1'b1;
                                end
                            end
                        end
                        ST_WAIT_ICW4: begin
                            if (w_is_data) begin
                                o_upm       <= i_din[0];
                                o_aeoi      <= i_din[1];
                                o_ms        <= i_din[2];
                                o_buf_mode  <= i_din[3];
                                o_sfnm      <= i_din[4];
                                r_state     <= ST_READY;
                                o_init_done <= 1'b1;
                            end
                        end
                        ST_READY: begin
                            if (w_is_data) begin
                                o_imr <= i_din;
                            end else if (w_is_ocw2) begin
                                o_ocw2_valid <= 1'b1;
                                o_ocw2_cmd   <= i_din[7:5];
                                o_ocw2_lvl   <= i_din[2:0];
                            end else if (w_is_ocw3) begin
                                if (i_din[1]) begin
                                    r_rd_isr <= i_din[0];
                                end
                                if (i_din[6]) begin
                                    o_smm <= i_din[5];
                                end
                                // Only sets: a later OCW3 without P keeps a pending poll
                                if (i_din[2]) begin
                                    r_poll <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            // UNINIT ignores everything but ICW1
                        end
                    endcase
                end
            end else if (i_rd_stb && r_poll) begin
                // A read coinciding with a write is dropped, so the poll survives it
                r_poll     <= 1'b0;
                o_poll_ack <= 1'b1;
            end
        end
    end

    always_comb begin
        if (r_poll) begin
            o_rd_src = C_RD_POLL;
        end else if (i_a0) begin
            o_rd_src = C_RD_IMR;
        end else if (r_rd_isr) begin
            o_rd_src = C_RD_ISR;
        end else begin
            o_rd_src = C_RD_IRR;
        end
    end

endmodule : pic_command_sequencer
`default_nettype wire
